// File: rtl/rf_trace_pkg.sv
// Shared types and frame-layout constants for the register-file trace transmitter.
// TRACE_CHECKSUM_EN adds the CHECK state and one trailing XOR checksum word per frame.
package rf_trace_pkg;

`ifdef TRACE_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_CHECK} state_e;
  localparam int CHECK_WORDS = 1;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA} state_e;
  localparam int CHECK_WORDS = 0;
`endif

  localparam int DEF_NUM_REGS  = 32;
  localparam int HDR_IDX       = 0;
  localparam int FIRST_REG_IDX = 1;
  localparam int FRAME_LEN     = FIRST_REG_IDX + DEF_NUM_REGS + CHECK_WORDS;

  // Frame length for an arbitrary register count.
  function automatic int frame_len(input int num_regs);
    return FIRST_REG_IDX + num_regs + CHECK_WORDS;
  endfunction

endpackage

// File: rtl/regfile_trace_tx_if.sv
// Trace stream interface: one word per edge where tx_valid && tx_ready.
// The master holds tx_valid, tx_data and tx_last stable while tx_valid && !tx_ready.
interface regfile_trace_tx_if #(
  parameter int XLEN = 32
);
  logic            tx_valid;
  logic            tx_ready;
  logic [XLEN-1:0] tx_data;
  logic            tx_last;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/rf_snapshot_buf.sv
// Latched copy of the register file, written on capture and read combinationally by index.
// Contents are intentionally not reset.
module rf_snapshot_buf #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clock,
  input  logic                     cap_en,
  input  logic [NUM_REGS*XLEN-1:0] reg_flat,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [XLEN-1:0]          rd_data
);

  logic [XLEN-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clock) begin
    if (cap_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= reg_flat[i*XLEN +: XLEN];
      end
    end
  end

  assign rd_data = r_mem[rd_idx];

endmodule

// File: rtl/regfile_trace_tx.sv
// Captures the register file on snap_req and streams {cycle stamp, x0..xN-1} as one frame.
// Optional macro TRACE_CHECKSUM_EN appends an XOR checksum word carrying tx_last.
module regfile_trace_tx
  import rf_trace_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     snap_req,
  input  logic [NUM_REGS*XLEN-1:0] reg_flat,
  output logic                     snap_busy,
  output logic [15:0]              drop_count,
  output state_e                   dbg_state,
  regfile_trace_tx_if.master       tx
);

  localparam int LEN   = frame_len(NUM_REGS);
  localparam int WI    = $clog2(LEN + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e          r_state;
  state_e          w_next_state;
  logic [XLEN-1:0] r_cyc;
  logic [XLEN-1:0] r_stamp;
  logic [WI-1:0]   r_word_idx;
  logic [15:0]     r_drop;

  logic             w_tx_valid;
  logic             w_tx_last;
  logic [XLEN-1:0]  w_tx_data;
  logic             w_fire;
  logic             w_capture;
  logic             w_drop;
  logic             w_last_reg;
  logic [IDX_W-1:0] w_rd_idx;
  logic [XLEN-1:0]  w_rd_data;

  assign w_fire     = w_tx_valid && tx.tx_ready;
  assign w_capture  = (r_state == ST_IDLE) && snap_req;
  assign w_drop     = (r_state != ST_IDLE) && snap_req;
  assign w_last_reg = (r_word_idx == WI'(NUM_REGS));
  assign w_rd_idx   = IDX_W'(r_word_idx - WI'(FIRST_REG_IDX));

  rf_snapshot_buf #(
    .NUM_REGS (NUM_REGS),
    .XLEN     (XLEN),
    .IDX_W    (IDX_W)
  ) u_buf (
    .clock    (clock),
    .cap_en   (w_capture),
    .reg_flat (reg_flat),
    .rd_idx   (w_rd_idx),
    .rd_data  (w_rd_data)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (snap_req) w_next_state = ST_HEADER;
      ST_HEADER: if (w_fire) w_next_state = ST_DATA;
`ifdef TRACE_CHECKSUM_EN
      ST_DATA:   if (w_fire && w_last_reg) w_next_state = ST_CHECK;
      ST_CHECK:  if (w_fire) w_next_state = ST_IDLE;
`else
      ST_DATA:   if (w_fire && w_last_reg) w_next_state = ST_IDLE;
`endif
      default:   w_next_state = ST_IDLE;
    endcase
  end

`ifdef TRACE_CHECKSUM_EN
  logic [XLEN-1:0] r_csum;

  // Seeded with the stamp so the final value covers every preceding frame word.
  always_ff @(posedge clock) begin
    if (w_capture) r_csum <= r_cyc;
    else if (w_fire && (r_state == ST_DATA)) r_csum <= r_csum ^ w_rd_data;
  end
`endif

  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    w_tx_last  = 1'b0;
    snap_busy  = (r_state != ST_IDLE);
    case (r_state)
      ST_HEADER: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_stamp;
      end
      ST_DATA: begin
        w_tx_valid = 1'b1;
        w_tx_data  = w_rd_data;
`ifdef TRACE_CHECKSUM_EN
        w_tx_last  = 1'b0;
`else
        w_tx_last  = w_last_reg;
`endif
      end
`ifdef TRACE_CHECKSUM_EN
      ST_CHECK: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_csum;
        w_tx_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cyc      <= '0;
      r_word_idx <= '0;
      r_drop     <= '0;
    end else begin
      r_cyc <= r_cyc + XLEN'(1);
      if (w_fire && w_tx_last) r_word_idx <= '0;
      else if (w_fire)         r_word_idx <= r_word_idx + WI'(1);
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_capture) r_stamp <= r_cyc;
  end

  assign tx.tx_valid = w_tx_valid;
  assign tx.tx_data  = w_tx_data;
  assign tx.tx_last  = w_tx_last;
  assign drop_count  = r_drop;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_regfile_trace_tx.sv
// Directed bench for regfile_trace_tx: expected frames go into exp_q, a monitor checks transfers.
// Build with TRACE_CHECKSUM_EN defined to exercise the checksum word.
module tb_regfile_trace_tx;
  import rf_trace_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
`ifdef TRACE_CHECKSUM_EN
  localparam int EXP_LEN  = NUM_REGS + 2;
`else
  localparam int EXP_LEN  = NUM_REGS + 1;
`endif

  logic                     clock;
  logic                     reset;
  logic                     snap_req;
  logic [NUM_REGS*XLEN-1:0] reg_flat;
  logic                     snap_busy;
  logic [15:0]              drop_count;
  state_e                   dbg_state;

  regfile_trace_tx_if #(.XLEN(XLEN)) tx_if ();

  regfile_trace_tx #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .snap_req   (snap_req),
    .reg_flat   (reg_flat),
    .snap_busy  (snap_busy),
    .drop_count (drop_count),
    .dbg_state  (dbg_state),
    .tx         (tx_if)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tb_cyc = 0;
  always @(posedge clock) begin
    if (!reset) tb_cyc = 0;
    else        tb_cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [XLEN:0]   exp_q[$];
  logic [XLEN-1:0] exp_regs [NUM_REGS];
  int n_tests = 0;
  int n_fail  = 0;
  int words_seen = 0;
  bit prev_stall = 1'b0;
  logic [XLEN-1:0] prev_data;
  logic prev_last;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle_edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_regs();
    for (int i = 0; i < NUM_REGS; i++) reg_flat[i*XLEN +: XLEN] = exp_regs[i];
  endtask

  task automatic push_frame(input logic [XLEN-1:0] stamp);
    logic [XLEN-1:0] csum;
    csum = stamp;
    exp_q.push_back({1'b0, stamp});
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef TRACE_CHECKSUM_EN
      exp_q.push_back({1'b0, exp_regs[i]});
`else
      exp_q.push_back({(i == NUM_REGS - 1), exp_regs[i]});
`endif
      csum = csum ^ exp_regs[i];
    end
`ifdef TRACE_CHECKSUM_EN
    exp_q.push_back({1'b1, csum});
`endif
  endtask

  task automatic send_snap(input logic [XLEN-1:0] stamp);
    push_frame(stamp);
    snap_req = 1'b1;
    @(posedge clock);
    #1;
    snap_req = 1'b0;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    @(posedge clock);
    #1;
    snap_req = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int cnt;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 300) begin
      @(negedge clock);
      cnt++;
    end
    n_tests++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
    check({name, "_valid_after"}, tx_if.tx_valid, 0);
    check({name, "_busy_after"}, snap_busy, 0);
  endtask

  // ready driver
  initial begin
    bit tog;
    tog = 1'b1;
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 1) begin
        tog = ~tog;
        tx_if.tx_ready = tog;
      end else begin
        tx_if.tx_ready = 1'b1;
      end
    end
  end

  // monitor
  initial begin
    logic [XLEN:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (prev_stall) begin
          check("stall_valid", tx_if.tx_valid, 1);
          check("stall_data", tx_if.tx_data, prev_data);
          check("stall_last", tx_if.tx_last, prev_last);
        end
        if (words_seen > 0) check("no_bubble", tx_if.tx_valid, 1);
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %h with no word expected", tx_if.tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_if.tx_data, e[XLEN-1:0]);
            check("tx_last", tx_if.tx_last, e[XLEN]);
            words_seen++;
            if (tx_if.tx_last) begin
              check("frame_len", words_seen, EXP_LEN);
              words_seen = 0;
            end
          end
        end
        prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data  = tx_if.tx_data;
        prev_last  = tx_if.tx_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // directed sequence
  initial begin
    reset    = 1'b0;
    snap_req = 1'b0;
    reg_flat = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", tx_if.tx_valid, 0);
    check("rst_last", tx_if.tx_last, 0);
    check("rst_data", tx_if.tx_data, 0);
    check("rst_busy", snap_busy, 0);
    check("rst_drop", drop_count, 0);
    reset = 1'b1;

    // basic frame, stamp 10 after reset release
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h100 + i;
    apply_regs();
    idle_edges(10);
    send_snap(32'd10);
    check("busy_in_frame", snap_busy, 1);
    wait_frame_done("basic");

    // back-pressure with ready toggling
    ready_mode = 1;
    idle_edges(2);
    send_snap(tb_cyc);
    wait_frame_done("stall");
    ready_mode = 0;

    // input changes after capture must not leak into the frame
    idle_edges(2);
    send_snap(tb_cyc);
    for (int i = 0; i < NUM_REGS; i++) reg_flat[i*XLEN +: XLEN] = 32'hDEADBEEF;
    wait_frame_done("latch");
    apply_regs();

    // dropped requests: three mid-frame, one on the last-word edge
    idle_edges(2);
    send_snap(tb_cyc);
    idle_edges(2);
    pulse_snap();
    idle_edges(6);
    pulse_snap();
    idle_edges(9);
    pulse_snap();
    idle_edges(EXP_LEN - 21);
    pulse_snap();
    wait_frame_done("drop");
    check("drop_count", drop_count, 4);
    idle_edges(40);
    check("drop_no_extra_valid", tx_if.tx_valid, 0);
    check("drop_no_extra_busy", snap_busy, 0);

    // reset mid-frame after word 5
    send_snap(tb_cyc);
    idle_edges(6);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_valid", tx_if.tx_valid, 0);
    check("midrst_busy", snap_busy, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_data", tx_if.tx_data, 0);
    exp_q.delete();
    words_seen = 0;
    reset = 1'b1;
    idle_edges(3);
    check("midrst_idle", tx_if.tx_valid, 0);
    send_snap(32'd3);
    wait_frame_done("after_rst");

    // all-zero registers, stamp 10
    reset = 1'b0;
    idle_edges(3);
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    apply_regs();
    idle_edges(10);
    send_snap(32'h0000000A);
    wait_frame_done("zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_trace_tx.md
REGFILE_TRACE_TX -- requirements
Module: regfile_trace_tx

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers captured per frame.
REQ-002 Parameter XLEN, default 32: register and stream word width.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock; reset==0 resets the block.
REQ-005 Port snap_req  input  1  one-cycle request to capture the register file.
REQ-006 Port reg_flat  input  NUM_REGS*XLEN  register values; x(i) at bits [i*XLEN +: XLEN].
REQ-007 Port snap_busy  output  1  high from capture until the last frame word is accepted.
REQ-008 Port tx_valid  output  1  stream word valid.
REQ-009 Port tx_ready  input  1  consumer ready.
REQ-010 Port tx_data  output  XLEN  stream word.
REQ-011 Port tx_last  output  1  marks the final word of a frame.
REQ-012 Port drop_count  output  16  number of snap_req pulses ignored while busy; saturates at 16'hFFFF.

Function
REQ-013 A free-running XLEN-bit cycle counter increments every non-reset cycle and wraps from all-ones to 0.
REQ-014 FSM states IDLE, HEADER, DATA, (CHECK when TRACE_CHECKSUM_EN); IDLE->HEADER on snap_req in IDLE.
REQ-015 On the edge accepting snap_req, reg_flat and the cycle counter value are latched; later reg_flat changes do not affect the frame.
REQ-016 Latency: snap_req high at edge N gives tx_valid=1 with header in the cycle after edge N.
REQ-017 Frame order: word 0 = latched cycle stamp; words 1..NUM_REGS = x0..x(NUM_REGS-1).
REQ-018 A word transfers only on an edge with tx_valid && tx_ready; the word index advances only then.
REQ-019 While tx_valid && !tx_ready, tx_data, tx_last and tx_valid hold unchanged.
REQ-020 tx_valid stays high, with no bubbles, from header until the last word transfers.
REQ-021 After the last word transfers, the FSM returns to IDLE; tx_valid=0 and snap_busy=0 in the following cycle.
REQ-022 A snap_req arriving on the same edge the last word transfers is dropped; a new request is accepted only in IDLE.
REQ-023 Each dropped snap_req increments drop_count by 1, saturating.
REQ-024 snap_busy = (state != IDLE).

Reset
REQ-025 While reset==0: state=IDLE, tx_valid=0, tx_last=0, tx_data=0, snap_busy=0, drop_count=0, cycle counter=0, word index=0.
REQ-026 Reset mid-frame aborts the frame immediately; no partial frame resumes afterward.
REQ-027 Snapshot storage is not reset; its contents are don't-care until the first capture.

Configuration
REQ-028 Macro TRACE_CHECKSUM_EN defined: after x(NUM_REGS-1), one extra word carries the XOR of all preceding frame words; tx_last is asserted only on that word; the frame is NUM_REGS+2 words long.
REQ-029 Macro TRACE_CHECKSUM_EN undefined: no CHECK state; tx_last is asserted on x(NUM_REGS-1); the frame is NUM_REGS+1 words long.

Structure
REQ-030 Package rf_trace_pkg holds the FSM state enum, the HDR_IDX/FIRST_REG_IDX constants, and the FRAME_LEN constant derived from the macro.
REQ-031 Sub-module rf_snapshot_buf holds the latched NUM_REGS x XLEN array, with a capture enable and a read index; it is combinationally read by word index.

Verification
REQ-032 Reset 3 cycles, then reg_flat x(i)=32'h100+i, snap_req at cycle 10, tx_ready=1 -> header=32'd10 relative to reset release, then 32'h100..32'h11F, tx_last on x31 (no macro), 33 consecutive valid cycles.
REQ-033 Same as REQ-032 with tx_ready toggling 1,0,1,0 -> identical word sequence; tx_data stable during every stall cycle.
REQ-034 Change reg_flat to all 32'hDEADBEEF the cycle after capture -> transmitted data is still 32'h100+i.
REQ-035 snap_req pulsed 3 times during one frame, plus once on the last-word transfer edge -> drop_count=4, exactly one frame sent.
REQ-036 reset=0 for one cycle after word 5 -> tx_valid=0 the next cycle, snap_busy=0, drop_count=0; a new snap_req produces a complete fresh frame.
REQ-037 TRACE_CHECKSUM_EN defined, all registers 0, stamp 32'h0000000A -> checksum word 32'h0000000A with tx_last, 34 words total.
